// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider for the RV32M divide group (DIV/DIVU/REM/REMU).
// Produces one quotient bit per cycle; divide-by-zero and signed overflow take a short path.
module mdu_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CALC = 3'd1;
  localparam logic [2:0] FIX  = 3'd2;
  localparam logic [2:0] FAST = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_dvd;
  logic [XLEN-1:0]  r_dsr;
  logic [XLEN-1:0]  r_quot;
  logic [XLEN-1:0]  r_rem;
  logic             r_negQ;
  logic             r_negR;
  logic             r_isRem;
  logic [XLEN-1:0]  r_final;
  logic [XLEN-1:0]  r_result;

  logic             w_accept;
  logic             w_signed;
  logic             w_rs1Neg;
  logic             w_rs2Neg;
  logic [XLEN-1:0]  w_abs1;
  logic [XLEN-1:0]  w_abs2;
  logic             w_divZero;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_specRes;
  logic [XLEN:0]    w_remShift;
  logic [XLEN:0]    w_diff;
  logic             w_qBit;
  logic [XLEN-1:0]  w_remNext;
  logic [XLEN-1:0]  w_fixRes;
  logic             w_valid;

  assign w_accept  = (r_state == IDLE) && start_i && funct3_i[2] && !kill_i;
  assign w_signed  = ~funct3_i[0];
  assign w_rs1Neg  = w_signed & rs1_i[XLEN-1];
  assign w_rs2Neg  = w_signed & rs2_i[XLEN-1];
  assign w_abs1    = w_rs1Neg ? -rs1_i : rs1_i;
  assign w_abs2    = w_rs2Neg ? -rs2_i : rs2_i;

  // RISC-V defines these results without trapping, so they bypass the iteration entirely.
  assign w_divZero = (rs2_i == '0);
  assign w_ovf     = w_signed && (rs1_i == MIN_NEG) && (rs2_i == '1);
  assign w_special = w_divZero || w_ovf;
  assign w_specRes = funct3_i[1] ? (w_divZero ? rs1_i : '0)
                                 : (w_divZero ? '1 : MIN_NEG);

  assign w_remShift = {r_rem, r_dvd[XLEN-1]};
  assign w_diff     = w_remShift - {1'b0, r_dsr};
  assign w_qBit     = ~w_diff[XLEN];
  assign w_remNext  = w_qBit ? w_diff[XLEN-1:0] : w_remShift[XLEN-1:0];

  assign w_fixRes = r_isRem ? (r_negR ? -r_rem : r_rem)
                            : (r_negQ ? -r_quot : r_quot);

  // A flush in DONE must swallow the pulse, so valid is gated combinationally.
  assign w_valid  = (r_state == DONE) && !kill_i;
  assign busy_o   = (r_state != IDLE);
  assign valid_o  = w_valid;
  assign result_o = w_valid ? r_final : r_result;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_isRem  <= 1'b0;
      r_final  <= '0;
      r_result <= '0;
    end else if (kill_i && (r_state != IDLE)) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvd   <= w_abs1;
            r_dsr   <= w_abs2;
            r_quot  <= '0;
            r_rem   <= '0;
            r_cnt   <= CNT_W'(XLEN - 1);
            r_negQ  <= w_rs1Neg ^ w_rs2Neg;
            r_negR  <= w_rs1Neg;
            r_isRem <= funct3_i[1];
            r_final <= w_specRes;
            r_state <= w_special ? FAST : CALC;
          end
        end
        CALC: begin
          r_rem  <= w_remNext;
          r_quot <= {r_quot[XLEN-2:0], w_qBit};
          r_dvd  <= {r_dvd[XLEN-2:0], 1'b0};
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_final <= w_fixRes;
          r_state <= DONE;
        end
        FAST: begin
          r_state <= DONE;
        end
        DONE: begin
          r_result <= r_final;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// Scoreboard bench for mdu_divider: expected result and arrival cycle are queued at issue
// and matched against each valid_o pulse.
module tb_mdu_divider;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        kill_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  logic [31:0] lastRes;

  mdu_divider #(.XLEN(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] refDiv(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    logic signed [31:0] r;
    sa  = a;
    sbv = b;
    if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
    if (!f[0]) begin
      r = f[1] ? (sa % sbv) : (sa / sbv);
      return r;
    end
    return f[1] ? (a % b) : (a / b);
  endfunction

  function automatic int refLat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  always @(negedge clk) begin
    if (rstn && valid_o) begin
      if (sb.size() == 0) begin
        checkOutput("strayValid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", result_o, e.res);
        checkOutput("latency", 32'(cyc), 32'(e.cyc));
        lastRes = e.res;
      end
    end
  end

  // Called at a negedge; issues one op and scrambles the operand inputs afterwards.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    funct3_i = f;
    rs1_i    = a;
    rs2_i    = b;
    start_i  = 1'b1;
    e.res    = refDiv(f, a, b);
    e.cyc    = cyc + refLat(f, a, b);
    sb.push_back(e);
    @(negedge clk);
    start_i  = 1'b0;
    rs1_i    = $urandom;
    rs2_i    = $urandom;
    funct3_i = 3'(($urandom_range(0, 7)));
    checkOutput("busyAfterAccept", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("timeout", 32'd1, 32'd0);
      sb.delete();
    end
    @(negedge clk);
    checkOutput("busyAfterDone", {31'd0, busy_o}, 32'd0);
    checkOutput("resultHold", result_o, lastRes);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc0;
    exp_t        e;

    rstn     = 1'b0;
    start_i  = 1'b0;
    kill_i   = 1'b0;
    funct3_i = 3'b000;
    rs1_i    = 32'h0;
    rs2_i    = 32'h0;
    lastRes  = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy_o}, 32'd0);
    checkOutput("rstValid", {31'd0, valid_o}, 32'd0);
    checkOutput("rstResult", result_o, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    applyStimulus(3'b101, 32'd100, 32'd7);              waitDone();
    applyStimulus(3'b111, 32'd100, 32'd7);              waitDone();
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2);        waitDone();
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2);        waitDone();
    applyStimulus(3'b110, 32'd7, 32'hFFFF_FFFE);        waitDone();
    applyStimulus(3'b101, 32'd5, 32'd0);                waitDone();
    applyStimulus(3'b110, 32'd5, 32'd0);                waitDone();
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF); waitDone();
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF); waitDone();
    for (int i = 0; i < 6; i++) begin
      f = 3'b100 | 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 0) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
      applyStimulus(f, a, b);
      waitDone();
    end

    // MUL-group funct3 must be ignored
    funct3_i = 3'b000;
    rs1_i    = 32'd9;
    rs2_i    = 32'd3;
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    checkOutput("mulIgnored", {31'd0, busy_o}, 32'd0);

    // kill coincident with start in IDLE
    funct3_i = 3'b101;
    start_i  = 1'b1;
    kill_i   = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    kill_i   = 1'b0;
    checkOutput("killAtStart", {31'd0, busy_o}, 32'd0);

    // kill in CALC cycle 10, then a fresh op one cycle later
    funct3_i = 3'b101;
    rs1_i    = 32'd1000;
    rs2_i    = 32'd3;
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    checkOutput("killBusy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    applyStimulus(3'b100, 32'd1000, 32'hFFFF_FFFD);
    waitDone();

    // reset mid-CALC
    funct3_i = 3'b101;
    rs1_i    = 32'd77;
    rs2_i    = 32'd5;
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("midRstBusy", {31'd0, busy_o}, 32'd0);
    checkOutput("midRstResult", result_o, 32'd0);
    lastRes = 32'h0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // start held high: one accept per 35-cycle period
    cyc0     = cyc;
    funct3_i = 3'b101;
    rs1_i    = 32'd1234;
    rs2_i    = 32'd10;
    start_i  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.res = 32'd123;
      e.cyc = cyc0 + 34 + 35 * k;
      sb.push_back(e);
    end
    repeat (104) @(negedge clk);
    #1;
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("heldQueueEmpty", 32'(sb.size()), 32'd0);
    checkOutput("heldIdle", {31'd0, busy_o}, 32'd0);
    sb.delete();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
